// File: rtl/machine_timer.sv
// machine_timer: memory-mapped RISC-V machine timer (mtime / mtimecmp / CTRL).
// Sits on the core data port and returns registered read data on RD_DATA.
// Registered read data is zero on an address miss, so it can be OR-ed with
// the memory read data.
// Optional feature macro: TIMER_SNAPSHOT_EN. When it is defined, a read of
// MTIME_LO latches mtime[63:32] into a shadow register. Later MTIME_HI reads
// return that shadow, so a LO-then-HI read pair is tear-free.
module machine_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] DATA_OUT,
  input  logic        WR_REQ,
  input  logic [3:0]  WR_MASK,
  output logic [31:0] RD_DATA,
  output logic [63:0] REAL_TIME,
  output logic        T_IRQ
);

  localparam logic [15:0] PRESCALE_LAST = PRESCALE[15:0] - 16'd1;

  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;

  logic [63:0] mtime_reg;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp_reg;
  logic [63:0] mtimecmp_next;
  logic        en_reg;
  logic        en_next;
  logic [15:0] presc_reg;
  logic [15:0] presc_next;
  logic        irq_reg;
  logic [31:0] rd_data_reg;
  logic [31:0] rd_data_next;
  logic [31:0] mtime_hi_rd;

  logic        sel;
  logic        wr_en;
  logic [2:0]  reg_idx;
  logic [31:0] bit_mask;
  logic        addr_unused;

  // The low address bits carry no meaning; registers are word-addressed.
  assign addr_unused = ^D_ADDR[1:0];

  assign sel     = (D_ADDR[31:5] == BASE_ADDR[31:5]);
  assign reg_idx = D_ADDR[4:2];
  assign wr_en   = WR_REQ && sel;

  // Expand the byte enables into a per-bit merge mask.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_mask
      assign bit_mask[gi*8 +: 8] = {8{WR_MASK[gi]}};
    end
  endgenerate

  function automatic logic [31:0] merge_word(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // mtime / prescaler next state: software writes win over the increment.
  always_comb begin
    mtime_next = mtime_reg;
    presc_next = presc_reg;
    if (wr_en && reg_idx == IDX_MTIME_LO) begin
      mtime_next[31:0] = merge_word(mtime_reg[31:0], DATA_OUT, bit_mask);
      presc_next       = '0;
    end else if (wr_en && reg_idx == IDX_MTIME_HI) begin
      mtime_next[63:32] = merge_word(mtime_reg[63:32], DATA_OUT, bit_mask);
      presc_next        = '0;
    end else if (en_reg) begin
      if (presc_reg == PRESCALE_LAST) begin
        presc_next = '0;
        mtime_next = mtime_reg + 64'd1;
      end else begin
        presc_next = presc_reg + 16'd1;
      end
    end
  end

  // mtimecmp and CTRL next state from byte-masked writes.
  always_comb begin
    mtimecmp_next = mtimecmp_reg;
    en_next       = en_reg;
    if (wr_en) begin
      case (reg_idx)
        IDX_CMP_LO: mtimecmp_next[31:0]  = merge_word(mtimecmp_reg[31:0], DATA_OUT, bit_mask);
        IDX_CMP_HI: mtimecmp_next[63:32] = merge_word(mtimecmp_reg[63:32], DATA_OUT, bit_mask);
        IDX_CTRL:   if (WR_MASK[0]) en_next = DATA_OUT[0];
        default:    ;
      endcase
    end
  end

  // Read mux: register contents before this cycle's write, zero on a miss.
  always_comb begin
    rd_data_next = '0;
    if (sel) begin
      case (reg_idx)
        IDX_MTIME_LO: rd_data_next = mtime_reg[31:0];
        IDX_MTIME_HI: rd_data_next = mtime_hi_rd;
        IDX_CMP_LO:   rd_data_next = mtimecmp_reg[31:0];
        IDX_CMP_HI:   rd_data_next = mtimecmp_reg[63:32];
        IDX_CTRL:     rd_data_next = {31'd0, en_reg};
        default:      rd_data_next = '0;
      endcase
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  logic [31:0] shadow_reg;

  // Capture the high word whenever the low word is read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow_reg <= '0;
    end else if (sel && reg_idx == IDX_MTIME_LO) begin
      shadow_reg <= mtime_reg[63:32];
    end
  end

  assign mtime_hi_rd = shadow_reg;
`else
  assign mtime_hi_rd = mtime_reg[63:32];
`endif

  // Timer state, read data and interrupt registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mtime_reg    <= '0;
      mtimecmp_reg <= '1;
      en_reg       <= 1'b1;
      presc_reg    <= '0;
      irq_reg      <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      en_reg       <= en_next;
      presc_reg    <= presc_next;
      irq_reg      <= (mtime_reg >= mtimecmp_reg);
      rd_data_reg  <= rd_data_next;
    end
  end

  assign RD_DATA   = rd_data_reg;
  assign REAL_TIME = mtime_reg;
  assign T_IRQ     = irq_reg;

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: two instances (PRESCALE 1 and 4) share one stimulus.
// A behavioural model of the register map is checked on every falling edge.
// Hand-computed expectations for the directed scenarios are checked as well.
module tb_machine_timer;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        CLK;
  logic        RESET;
  logic [31:0] D_ADDR;
  logic [31:0] DATA_OUT;
  logic        WR_REQ;
  logic [3:0]  WR_MASK;
  logic [31:0] rd_w  [2];
  logic [63:0] rt_w  [2];
  logic        irq_w [2];

  int n_cmp = 0;
  int n_bad = 0;

  machine_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) u0 (
    .CLK(CLK), .RESET(RESET), .D_ADDR(D_ADDR), .DATA_OUT(DATA_OUT),
    .WR_REQ(WR_REQ), .WR_MASK(WR_MASK),
    .RD_DATA(rd_w[0]), .REAL_TIME(rt_w[0]), .T_IRQ(irq_w[0])
  );

  machine_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) u4 (
    .CLK(CLK), .RESET(RESET), .D_ADDR(D_ADDR), .DATA_OUT(DATA_OUT),
    .WR_REQ(WR_REQ), .WR_MASK(WR_MASK),
    .RD_DATA(rd_w[1]), .REAL_TIME(rt_w[1]), .T_IRQ(irq_w[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic        m_en   [2];
  int          m_pc   [2];
  logic        m_irq  [2];
  logic [31:0] m_rd   [2];
  logic [31:0] m_sh   [2];

  function automatic logic [63:0] byte_bits(input logic [3:0] mask, input bit upper);
    logic [63:0] b = '0;
    for (int i = 0; i < 4; i++)
      if (mask[i]) b[(upper ? 32 : 0) + i*8 +: 8] = 8'hFF;
    return b;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < 2; k++) begin
        m_time[k] <= 64'd0;
        m_cmp[k]  <= '1;
        m_en[k]   <= 1'b1;
        m_pc[k]   <= 0;
        m_irq[k]  <= 1'b0;
        m_rd[k]   <= 32'd0;
        m_sh[k]   <= 32'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int          p;
        int          pc;
        int          idx;
        bit          hit;
        bit          wr;
        logic [63:0] t;
        logic [63:0] c;
        logic [63:0] wd;
        logic [63:0] bb;
        logic [31:0] r;
        logic        e;
        p   = (k == 0) ? 1 : 4;
        hit = (D_ADDR[31:5] == BASE[31:5]);
        idx = int'(D_ADDR[4:2]);
        wr  = WR_REQ && hit;
        t   = m_time[k];
        c   = m_cmp[k];
        e   = m_en[k];
        pc  = m_pc[k];
        wd  = {DATA_OUT, DATA_OUT};
        case (idx)
          0: r = t[31:0];
`ifdef TIMER_SNAPSHOT_EN
          1: r = m_sh[k];
`else
          1: r = t[63:32];
`endif
          2: r = c[31:0];
          3: r = c[63:32];
          4: r = {31'd0, e};
          default: r = 32'd0;
        endcase
        if (!hit) r = 32'd0;
        if (hit && idx == 0) m_sh[k] <= t[63:32];
        m_rd[k]  <= r;
        m_irq[k] <= (t >= c);
        if (wr && (idx == 0 || idx == 1)) begin
          bb = byte_bits(WR_MASK, idx == 1);
          t  = (t & ~bb) | (wd & bb);
          pc = 0;
        end else if (e) begin
          pc = pc + 1;
          if (pc == p) begin
            pc = 0;
            t  = t + 1;
          end
        end
        if (wr && (idx == 2 || idx == 3)) begin
          bb = byte_bits(WR_MASK, idx == 3);
          c  = (c & ~bb) | (wd & bb);
        end
        if (wr && idx == 4 && WR_MASK[0]) e = DATA_OUT[0];
        m_time[k] <= t;
        m_cmp[k]  <= c;
        m_en[k]   <= e;
        m_pc[k]   <= pc;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_rt[%0d]", k), rt_w[k], m_time[k]);
      check($sformatf("model_irq[%0d]", k), {63'd0, irq_w[k]}, {63'd0, m_irq[k]});
      check($sformatf("model_rd[%0d]", k), {32'd0, rd_w[k]}, {32'd0, m_rd[k]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] data, input logic [3:0] mask);
    D_ADDR   = BASE + {27'd0, off};
    DATA_OUT = data;
    WR_MASK  = mask;
    WR_REQ   = 1'b1;
    tick();
    WR_REQ   = 1'b0;
    D_ADDR   = 32'd0;
  endtask

  task automatic rd(input logic [4:0] off);
    D_ADDR = BASE + {27'd0, off};
    tick();
    D_ADDR = 32'd0;
  endtask

  logic [63:0] held0;
  logic [63:0] held4;
  bit          seen;

  initial begin
    RESET = 1'b1; D_ADDR = 32'd0; DATA_OUT = 32'd0; WR_REQ = 1'b0; WR_MASK = 4'h0;
    repeat (3) tick();
    check("reset_rt", rt_w[0], 64'd0);
    check("reset_irq", {63'd0, irq_w[0]}, 64'd0);
    check("reset_rd", {32'd0, rd_w[0]}, 64'd0);
    RESET = 1'b0;
    repeat (10) tick();
    check("count10_p1", rt_w[0], 64'd10);
    check("count10_p4", rt_w[1], 64'd2);
    check("count_irq", {63'd0, irq_w[0]}, 64'd0);

    // carry from low to high word
    wr(5'h00, 32'hFFFF_FFFF, 4'hF);
    wr(5'h04, 32'h0, 4'hF);
    check("carry_loaded", rt_w[0], 64'h0000_0000_FFFF_FFFF);
    tick();
    tick();
    check("carry", rt_w[0], 64'h0000_0001_0000_0001);

    // wrap from all-ones to zero
    wr(5'h00, 32'hFFFF_FFFF, 4'hF);
    wr(5'h04, 32'hFFFF_FFFF, 4'hF);
    check("allones", rt_w[0], 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("wrap", rt_w[0], 64'd0);
    check("wrap_irq", {63'd0, irq_w[0]}, 64'd1);

    // interrupt at mtimecmp = 20
    wr(5'h04, 32'h0, 4'hF);
    wr(5'h00, 32'h0, 4'hF);
    check("zeroed", rt_w[0], 64'd0);
    wr(5'h0C, 32'h0, 4'hF);
    wr(5'h08, 32'd20, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (irq_w[0]) begin
        seen = 1'b1;
        check("irq_rise_time", rt_w[0], 64'd21);
      end
    end
    if (!seen) check("irq_rise_timeout", 64'd0, 64'd1);
    wr(5'h0C, 32'h1, 4'hF);
    check("irq_still_high", {63'd0, irq_w[0]}, 64'd1);
    tick();
    check("irq_fall", {63'd0, irq_w[0]}, 64'd0);

    // asynchronous reset mid-count, then byte-masked write
    RESET = 1'b1;
    #1;
    check("async_reset_rt", rt_w[0], 64'd0);
    check("async_reset_irq", {63'd0, irq_w[0]}, 64'd0);
    tick();
    RESET = 1'b0;
    wr(5'h08, 32'hAABB_CCDD, 4'b0101);
    rd(5'h08);
    check("byte_mask", {32'd0, rd_w[0]}, 64'h0000_0000_FFBB_FFDD);

    // enable off freezes mtime
    wr(5'h10, 32'h0, 4'hF);
    held0 = rt_w[0];
    held4 = rt_w[1];
    repeat (50) tick();
    check("frozen_p1", rt_w[0], held0);
    check("frozen_p4", rt_w[1], held4);
    rd(5'h10);
    check("ctrl_read", {32'd0, rd_w[0]}, 64'd0);

    // re-enable, prescale 4 cadence from a cleared prescaler
    wr(5'h10, 32'h1, 4'hF);
    wr(5'h00, 32'h0, 4'hF);
    check("p4_loaded", rt_w[1], 64'd0);
    repeat (3) tick();
    check("p4_3cyc", rt_w[1], 64'd0);
    tick();
    check("p4_4cyc", rt_w[1], 64'd1);
    repeat (4) tick();
    check("p4_8cyc", rt_w[1], 64'd2);
    repeat (3) tick();
    wr(5'h00, 32'hCAFE_0000, 4'hF);
    check("prio_p4", rt_w[1], 64'h0000_0000_CAFE_0000);
    check("prio_p1", rt_w[0], 64'h0000_0000_CAFE_0000);
    tick();
    check("prio_p4_hold", rt_w[1], 64'h0000_0000_CAFE_0000);

    // snapshot behaviour for a LO-then-HI read pair
    wr(5'h04, 32'h0, 4'hF);
    wr(5'h00, 32'hFFFF_FFFE, 4'hF);
    rd(5'h00);
    check("snap_lo", {32'd0, rd_w[0]}, 64'h0000_0000_FFFF_FFFE);
    repeat (5) tick();
    check("miss_zero", {32'd0, rd_w[0]}, 64'd0);
    rd(5'h04);
`ifdef TIMER_SNAPSHOT_EN
    check("snap_hi", {32'd0, rd_w[0]}, 64'd0);
`else
    check("snap_hi", {32'd0, rd_w[0]}, 64'd1);
`endif
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped RISC-V machine timer sitting beside data memory on the core's data port. Decodes the core's data address, write request, write mask and write data. Owns the 64-bit mtime and mtimecmp registers and returns registered read data for the core's load path. Drives the core's REAL_TIME bus and T_IRQ line.

## Interface

**Parameters**
- BASE_ADDR, 32'h0001_0000: byte address of register block; must be 32-byte aligned.
- PRESCALE, 1: clock cycles per mtime increment; legal range 1..65535.

**Ports**
- CLK, input, 1: clock; all state updates on the rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- D_ADDR, input, 32: core data address (same cycle as WR_REQ).
- DATA_OUT, input, 32: core store data.
- WR_REQ, input, 1: store strobe, valid for one cycle.
- WR_MASK, input, 4: byte enables; bit i enables byte i.
- RD_DATA, output, 32: registered read data. It is 0 when the previous-cycle address missed, so it can be OR-ed with the memory's DATA_IN.
- REAL_TIME, output, 64: current mtime value.
- T_IRQ, output, 1: timer interrupt, level, registered.

## Operation

**Register map.** Select is D_ADDR[31:5] == BASE_ADDR[31:5]; the register is chosen by D_ADDR[4:2]; D_ADDR[1:0] is ignored.
- +0x00 MTIME_LO
- +0x04 MTIME_HI
- +0x08 MTIMECMP_LO
- +0x0C MTIMECMP_HI
- +0x10 CTRL: bit0 EN, reset 1; other bits read 0, writes ignored.
- +0x14..+0x1C reserved: read 0, writes ignored.

**Reset values**
- mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, EN = 1.
- Prescaler = 0, T_IRQ = 0, RD_DATA = 0, REAL_TIME = 0.

**Prescaler and counting**
- The prescaler counts 0..PRESCALE-1 while EN = 1 and holds its value while EN = 0.
- mtime increments by 1 in the cycle the prescaler is at PRESCALE-1, and the prescaler returns to 0.
- With PRESCALE = 1, mtime increments every cycle.
- mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag. Carry from the low word to the high word happens in the same cycle.

**Writes**
- A write happens when WR_REQ = 1 and the address is selected; each byte is updated per WR_MASK.
- A write to MTIME_LO or MTIME_HI takes priority over an increment in the same cycle: the written half takes the new bytes, and the other half is held with no increment or carry.
- Any mtime write also clears the prescaler to 0.
- A write to CTRL with EN = 0 freezes mtime from the next cycle.

**Reads**
- Every cycle, RD_DATA is loaded with the selected register's value (pre-write value if a write hits the same cycle), or 0 on a miss.
- Reads have no side effects except when snapshot is enabled (see Configuration).

**Interrupt.** T_IRQ(n+1) = (mtime(n) >= mtimecmp(n)), compared as unsigned 64-bit.

## Timing

- Read latency is 1 cycle: an address presented in cycle n gives valid RD_DATA in cycle n+1. This matches the core sampling load data one stage after issuing the address.
- Write latency is 1 cycle: a register written in cycle n shows its new value from cycle n+1; RD_DATA for an address in cycle n+1 returns it in cycle n+2.
- REAL_TIME equals the mtime register with no extra delay.
- T_IRQ lags the compare condition by exactly 1 cycle. A write in cycle n that makes the compare true raises T_IRQ in cycle n+2; the same applies when it clears the compare.
- Asserting RESET at any time, including mid-count or with T_IRQ high, forces all reset values immediately. Counting resumes on the first clock edge after RESET falls.

## Configuration

- **TIMER_SNAPSHOT_EN defined**
  - Every read of MTIME_LO (cycle n) latches mtime[63:32] into a 32-bit shadow register at the edge ending cycle n.
  - Reads of MTIME_HI return the shadow; the shadow resets to 0.
  - This gives tear-free 64-bit reads (LO then HI).
- **TIMER_SNAPSHOT_EN undefined**
  - No shadow register exists.
  - MTIME_HI reads return live mtime[63:32].

## Test plan

- **Reset and count:** RESET high 3 cycles then low, PRESCALE = 1 → REAL_TIME = 0 during reset; REAL_TIME = 10 ten edges after release; T_IRQ = 0; RD_DATA = 0.
- **Carry and wrap:**
  - Write MTIME_LO = 32'hFFFF_FFFF with mask 4'hF, then MTIME_HI = 32'h0 → two increments later REAL_TIME = 64'h0000_0001_0000_0001.
  - Write both halves to all-ones → next cycle REAL_TIME = 0.
- **Interrupt:**
  - mtime = 0, write MTIMECMP_HI = 0, then MTIMECMP_LO = 20 → T_IRQ rises exactly when REAL_TIME = 21.
  - Write MTIMECMP_HI = 1 → T_IRQ falls 2 cycles after that write.
- **Byte mask:** write MTIMECMP_LO with data 32'hAABBCCDD and mask 4'b0101 from reset → read returns 32'hFFBBFFDD one cycle after address.
- **Enable/priority:**
  - Write CTRL = 0 → REAL_TIME is constant for 50 cycles.
  - Write CTRL = 1 with PRESCALE = 4 → REAL_TIME increments every 4 cycles.
  - A mtime write in the same cycle as a terminal count loads the written value exactly.
- **Snapshot:** mtime = 64'h0000_0000_FFFF_FFFE; read LO, wait 5 cycles, read HI → HI reads 0 with TIMER_SNAPSHOT_EN and 1 without it; an address miss returns RD_DATA = 0.
